// File: rtl/fractcam_prio_enc.sv
// Two-stage elastic priority encoder for the FractCAM match vector: the lowest
// set entry wins, with hit/multi flags and a sideband tag carried alongside.
module fractcam_prio_enc #(
    parameter int unsigned D         = 64,
    parameter int unsigned TAG_WIDTH = 8,
    localparam int unsigned IDX_WIDTH = $clog2(D)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [D-1:0]         s_match,
    input  logic [TAG_WIDTH-1:0] s_tag,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic [IDX_WIDTH-1:0] m_idx,
    output logic                 m_hit,
    output logic                 m_multi,
    output logic [TAG_WIDTH-1:0] m_tag,
    output logic                 m_valid,
    input  logic                 m_ready
);

    localparam int unsigned G  = D / 4;
    localparam int unsigned GW = IDX_WIDTH - 2;

    logic                 st1_adv;
    logic                 st2_adv;

    logic [G-1:0]         grp_hit_d,   grp_hit_q;
    logic [G-1:0]         grp_multi_d, grp_multi_q;
    logic [G-1:0][1:0]    grp_idx_d,   grp_idx_q;
    logic [TAG_WIDTH-1:0] tag1_q;
    logic                 st1_valid_q;
    logic [3:0]           nib;

    logic [IDX_WIDTH-1:0] m_idx_d,   m_idx_q;
    logic                 m_hit_d,   m_hit_q;
    logic                 m_multi_d, m_multi_q;
    logic [TAG_WIDTH-1:0] m_tag_q;
    logic                 m_valid_q;
    logic                 found;

    // A stage may take a new beat when it is empty or its contents move on
    assign st2_adv = ~m_valid_q | m_ready;
    assign st1_adv = ~st1_valid_q | st2_adv;
    assign s_ready = st1_adv;

    // Stage 1: per-nibble hit, lowest position and multi-hit
    always_comb begin
        grp_hit_d   = '0;
        grp_multi_d = '0;
        grp_idx_d   = '0;
        nib         = '0;
        for (int unsigned g = 0; g < G; g++) begin
            nib            = s_match[4*g +: 4];
            grp_hit_d[g]   = |nib;
            grp_multi_d[g] = (nib & (nib - 4'd1)) != 4'd0;
            if (nib[0])      grp_idx_d[g] = 2'd0;
            else if (nib[1]) grp_idx_d[g] = 2'd1;
            else if (nib[2]) grp_idx_d[g] = 2'd2;
            else if (nib[3]) grp_idx_d[g] = 2'd3;
            else             grp_idx_d[g] = 2'd0;
        end
    end

    // Stage 2: lowest hitting group selects the upper index bits
    always_comb begin
        m_idx_d = '0;
        found   = 1'b0;
        for (int unsigned g = 0; g < G; g++) begin
            if (!found && grp_hit_q[g]) begin
                found   = 1'b1;
                m_idx_d = {GW'(g), grp_idx_q[g]};
            end
        end
        m_hit_d   = |grp_hit_q;
        m_multi_d = (|grp_multi_q) | ((grp_hit_q & (grp_hit_q - G'(1))) != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st1_valid_q <= 1'b0;
            grp_hit_q   <= '0;
            grp_multi_q <= '0;
            grp_idx_q   <= '0;
            tag1_q      <= '0;
            m_valid_q   <= 1'b0;
            m_idx_q     <= '0;
            m_hit_q     <= 1'b0;
            m_multi_q   <= 1'b0;
            m_tag_q     <= '0;
        end else begin
            if (st1_adv) begin
                st1_valid_q <= s_valid;
                if (s_valid) begin
                    grp_hit_q   <= grp_hit_d;
                    grp_multi_q <= grp_multi_d;
                    grp_idx_q   <= grp_idx_d;
                    tag1_q      <= s_tag;
                end
            end
            if (st2_adv) begin
                m_valid_q <= st1_valid_q;
                if (st1_valid_q) begin
                    m_idx_q   <= m_idx_d;
                    m_hit_q   <= m_hit_d;
                    m_multi_q <= m_multi_d;
                    m_tag_q   <= tag1_q;
                end
            end
        end
    end

    assign m_idx   = m_idx_q;
    assign m_hit   = m_hit_q;
    assign m_multi = m_multi_q;
    assign m_tag   = m_tag_q;
    assign m_valid = m_valid_q;

endmodule

// File: tb/tb_fractcam_prio_enc.sv
// Randomized and directed bench for fractcam_prio_enc against a scoreboard of
// accepted beats whose results come from a plain bit-scan reference.
module tb_fractcam_prio_enc;

    localparam int unsigned D  = 64;
    localparam int unsigned TW = 8;
    localparam int unsigned IW = 6;

    logic          clk;
    logic          rst;
    logic [D-1:0]  s_match;
    logic [TW-1:0] s_tag;
    logic          s_valid;
    logic          s_ready;
    logic [IW-1:0] m_idx;
    logic          m_hit;
    logic          m_multi;
    logic [TW-1:0] m_tag;
    logic          m_valid;
    logic          m_ready;

    fractcam_prio_enc #(.D(D), .TAG_WIDTH(TW)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_match (s_match),
        .s_tag   (s_tag),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .m_idx   (m_idx),
        .m_hit   (m_hit),
        .m_multi (m_multi),
        .m_tag   (m_tag),
        .m_valid (m_valid),
        .m_ready (m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] match;
        logic [7:0]  tag;
        int          acc;
    } beat_t;

    beat_t         q[$];
    int            n_chk = 0;
    int            n_bad = 0;
    int            cyc = 0;
    int            n_out = 0;
    bit            chk_lat = 0;
    bit            prev_stall = 0;
    logic [IW-1:0] p_idx;
    logic          p_hit, p_multi;
    logic [TW-1:0] p_tag;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Reference: scan for the lowest set bit, count ones for multi
    function automatic void model(input logic [63:0] mt, output logic [5:0] idx,
                                  output logic hit, output logic multi);
        idx = 6'd0;
        hit = 1'b0;
        for (int i = 63; i >= 0; i--) begin
            if (mt[i]) begin
                idx = 6'(i);
                hit = 1'b1;
            end
        end
        multi = $countones(mt) > 1;
    endfunction

    function automatic logic [63:0] rand_match();
        logic [63:0] one;
        one = 64'd1;
        case ($urandom % 4)
            0:       return 64'd0;
            1:       return one << ($urandom % 64);
            2:       return {$urandom, $urandom};
            default: return (one << ($urandom % 64)) | (one << ($urandom % 64));
        endcase
    endfunction

    // One cycle: drive at negedge, check settled outputs, update scoreboard
    task automatic step(input logic v, input logic [63:0] mt, input logic [7:0] tg,
                        input logic mr, input logic r);
        beat_t         b;
        logic [5:0]    e_idx;
        logic          e_hit, e_multi;
        @(negedge clk);
        rst     = r;
        s_valid = v;
        s_match = mt;
        s_tag   = tg;
        m_ready = mr;
        #1;
        if (prev_stall) begin
            chk("stall_valid", 64'(m_valid), 64'd1);
            chk("stall_idx",   64'(m_idx),   64'(p_idx));
            chk("stall_hit",   64'(m_hit),   64'(p_hit));
            chk("stall_multi", 64'(m_multi), 64'(p_multi));
            chk("stall_tag",   64'(m_tag),   64'(p_tag));
        end
        chk("s_ready", 64'(s_ready), 64'(!(q.size() == 2 && !mr)));
        if (m_valid) begin
            if (q.size() == 0) begin
                chk("spurious_valid", 64'(m_valid), 64'd0);
            end else if (mr) begin
                b = q.pop_front();
                model(b.match, e_idx, e_hit, e_multi);
                chk("idx",   64'(m_idx),   64'(e_idx));
                chk("hit",   64'(m_hit),   64'(e_hit));
                chk("multi", 64'(m_multi), 64'(e_multi));
                chk("tag",   64'(m_tag),   64'(b.tag));
                if (chk_lat) chk("latency", 64'(cyc - b.acc), 64'd2);
                n_out++;
            end
        end
        prev_stall = m_valid && !mr && !r;
        p_idx   = m_idx;
        p_hit   = m_hit;
        p_multi = m_multi;
        p_tag   = m_tag;
        if (v && s_ready && !r) begin
            b.match = mt;
            b.tag   = tg;
            b.acc   = cyc;
            q.push_back(b);
        end
        if (r) q.delete();
        cyc++;
    endtask

    // Isolated beat with known answer; also pins the two-cycle latency
    task automatic dir(input string nm, input logic [63:0] mt, input logic [7:0] tg,
                       input logic [5:0] eidx, input logic ehit, input logic emulti);
        step(1'b1, mt, tg, 1'b1, 1'b0);
        step(1'b0, 64'd0, 8'd0, 1'b1, 1'b0);
        chk({nm, "_early"}, 64'(m_valid), 64'd0);
        step(1'b0, 64'd0, 8'd0, 1'b1, 1'b0);
        chk({nm, "_valid"}, 64'(m_valid), 64'd1);
        chk({nm, "_idx"},   64'(m_idx),   64'(eidx));
        chk({nm, "_hit"},   64'(m_hit),   64'(ehit));
        chk({nm, "_multi"}, 64'(m_multi), 64'(emulti));
        chk({nm, "_tag"},   64'(m_tag),   64'(tg));
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_valid"}, 64'(m_valid), 64'd0);
        chk({nm, "_ready"}, 64'(s_ready), 64'd1);
        chk({nm, "_idx"},   64'(m_idx),   64'd0);
        chk({nm, "_hit"},   64'(m_hit),   64'd0);
        chk({nm, "_multi"}, 64'(m_multi), 64'd0);
        chk({nm, "_tag"},   64'(m_tag),   64'd0);
    endtask

    initial begin
        int base;
        rst = 1'b1; s_valid = 1'b0; s_match = '0; s_tag = '0; m_ready = 1'b0;
        step(1'b0, 64'd0, 8'd0, 1'b0, 1'b1);
        step(1'b0, 64'd0, 8'd0, 1'b0, 1'b1);
        step(1'b0, 64'd0, 8'd0, 1'b1, 1'b0);
        chk_zero("reset");

        dir("single",  64'h0000_0000_0001_0000, 8'h5A, 6'd16, 1'b1, 1'b0);
        dir("prio",    64'h8000_0000_0000_0120, 8'h11, 6'd5,  1'b1, 1'b1);
        dir("ingroup", 64'h0000_0000_0000_0003, 8'h22, 6'd0,  1'b1, 1'b1);
        dir("nohit",   64'h0000_0000_0000_0000, 8'h33, 6'd0,  1'b0, 1'b0);
        dir("top",     64'h8000_0000_0000_0000, 8'h44, 6'd63, 1'b1, 1'b0);

        // Back-to-back beats at full rate
        chk_lat = 1;
        base = n_out;
        for (int i = 0; i < 100; i++)
            step(1'b1, rand_match(), 8'($urandom), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b0, 64'd0, 8'd0, 1'b1, 1'b0);
        chk("thru_count", 64'(n_out - base), 64'd100);
        chk_lat = 0;

        // Random valid/ready
        for (int i = 0; i < 400; i++)
            step(1'($urandom % 2), rand_match(), 8'($urandom), 1'($urandom % 2), 1'b0);
        for (int i = 0; i < 5; i++)
            step(1'b0, 64'd0, 8'd0, 1'b1, 1'b0);
        chk("drain_empty", 64'(q.size()), 64'd0);

        // Fill under stall, then reset mid-stream
        for (int i = 0; i < 3; i++)
            step(1'b1, rand_match() | 64'd1, 8'($urandom), 1'b0, 1'b0);
        chk("full_ready", 64'(s_ready), 64'd0);
        step(1'b0, 64'd0, 8'd0, 1'b0, 1'b1);
        step(1'b0, 64'd0, 8'd0, 1'b1, 1'b0);
        chk_zero("midrst");
        step(1'b0, 64'd0, 8'd0, 1'b1, 1'b0);
        chk("midrst_quiet", 64'(m_valid), 64'd0);
        dir("postrst", 64'h0000_0000_0000_0F00, 8'hC3, 6'd8, 1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
